dsa_control_fsm_simd: RTL and testbench
=======================================

Name: dsa_control_fsm_simd

Overview:
- Parametrised successor to the sequential pixel-control FSM.
- Walks the output image in raster order, LANES pixels per iteration; groups never cross a row boundary.
- Sequences fetch -> datapath -> write handshakes per group and drives a per-lane valid mask for partial groups at the row tail.
- Sits between the top-level controller and the SIMD fetch unit / interpolation datapath / write-back path.

Parameters:
- LANES, 4, pixels processed per iteration (power of two, 1..16).
- COORD_W, 16, width of coordinate and dimension buses.
- CNT_W, 32, width of the processed-pixel counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle start pulse; sampled only in ST_IDLE or ST_DONE.
- abort  in  1  abandon current frame.
- img_width_out  in  COORD_W  output image width; latched at start.
- img_height_out  in  COORD_W  output image height; latched at start.
- fetch_req  out  1  one-cycle pulse requesting fetch of the group at (current_x, current_y).
- fetch_done  in  1  fetch complete.
- dp_start  out  1  one-cycle pulse starting the datapath.
- dp_done  in  1  datapath complete.
- write_enable  out  1  write strobe; held until write_ready.
- write_ready  in  1  write path accepts the group.
- lane_valid  out  LANES  bit i set if pixel current_x+i lies inside the row.
- current_x  out  COORD_W  x of lane 0.
- current_y  out  COORD_W  current row.
- pixels_processed  out  CNT_W  pixels written so far this frame.
- busy  out  1  high in every state except ST_IDLE and ST_DONE.
- ready  out  1  high in ST_DONE.
- done_pulse  out  1  one-cycle pulse on entry to ST_DONE.

Behaviour:
- Reset (rst_n=0 at posedge clk): state ST_IDLE.
  - All outputs 0: fetch_req, dp_start, write_enable, lane_valid, current_x, current_y, pixels_processed, busy, ready, done_pulse.
  - Latched dimensions cleared.
- States: ST_IDLE, ST_INIT, ST_REQ_FETCH, ST_WAIT_FETCH, ST_START_DP, ST_WAIT_DP, ST_WRITE, ST_NEXT, ST_DONE.
- ST_IDLE / ST_DONE + start:
  - Latch W = img_width_out and H = img_height_out.
  - Clear x, y and pixels_processed.
  - Go to ST_INIT.
- ST_INIT: if W==0 or H==0, go to ST_DONE (pixels_processed stays 0); otherwise go to ST_REQ_FETCH.
- ST_REQ_FETCH: fetch_req=1 for one cycle -> ST_WAIT_FETCH.
- ST_WAIT_FETCH: wait for fetch_done -> ST_START_DP. A fetch_done arriving in the same cycle as fetch_req is ignored.
- ST_START_DP: dp_start=1 for one cycle -> ST_WAIT_DP.
- ST_WAIT_DP: wait for dp_done -> ST_WRITE.
- ST_WRITE:
  - write_enable=1 and held until write_ready=1.
  - The cycle with write_enable & write_ready is the transfer -> ST_NEXT.
- ST_NEXT, one cycle:
  - pixels_processed += popcount(lane_valid).
  - If x+LANES < W: x += LANES.
  - Else: x = 0, y += 1.
  - If the group was the last group of row H-1 -> ST_DONE; else -> ST_REQ_FETCH.
- lane_valid:
  - Combinational from registered x: bit i = (x+i < W), compared in COORD_W+1 bits so x+i never wraps.
  - Forced to 0 outside ST_REQ_FETCH..ST_NEXT.
- Iteration count per frame: H * ceil(W/LANES). Every group takes at least 6 cycles.
- Exit condition uses latched W/H only. Input dimension changes mid-frame have no effect.
- ST_DONE:
  - ready=1; done_pulse=1 on the entry cycle only.
  - Remains until start, which restarts directly.
  - pixels_processed holds W*H until the restart.
- abort, any state except ST_IDLE: next state ST_IDLE; all strobes drop the following cycle; counters keep their values. abort has priority over start and handshakes in the same cycle.
- start while busy is ignored.
- Product W*H must fit CNT_W; W,H <= 2^COORD_W-1.

Optional Feature:
- Macro DSA_FSM_PERF_COUNTERS_EN.
- When defined, adds two output ports:
  - perf_cycles (32 bits): increments every cycle busy=1.
  - perf_stall (32 bits): increments every cycle in ST_WAIT_FETCH without fetch_done, in ST_WAIT_DP without dp_done, or in ST_WRITE without write_ready.
  - Both clear on start, hold in ST_DONE and ST_IDLE, and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- LANES=4, W=8, H=2, fetch_done/dp_done/write_ready returned 1 cycle after request:
  - exactly 4 fetch_req pulses at (0,0),(4,0),(0,1),(4,1), lane_valid=4'b1111 each;
  - pixels_processed=16, one done_pulse.
- LANES=4, W=5, H=1:
  - groups at x=0 (lane_valid 4'b1111) and x=4 (lane_valid 4'b0001);
  - pixels_processed=5, current_y stays 0.
- W=0, H=7, start:
  - ST_DONE reached 2 cycles after start with no fetch_req;
  - pixels_processed=0, ready=1.
- W=4, H=4, write_ready held low 10 cycles on first group:
  - write_enable stays high 10 cycles, no coordinate advance;
  - with DSA_FSM_PERF_COUNTERS_EN, perf_stall >= 10.
- abort asserted in ST_WAIT_DP of second group:
  - next cycle busy=0, dp_start/write_enable/fetch_req=0, state ST_IDLE;
  - a following start with W=4, H=1 completes with pixels_processed=4.
- rst_n=0 for one cycle mid-frame, then start with W=12, H=3, LANES=4:
  - all outputs 0 after reset;
  - new frame issues 9 fetch_req pulses and ends with pixels_processed=36.

Source files
------------

// File: rtl/dsa_control_fsm_simd.sv
// Raster-order SIMD pixel-control FSM: fetch -> datapath -> write per LANES-wide group.
// Define DSA_FSM_PERF_COUNTERS_EN to add perf_cycles / perf_stall outputs.
module dsa_control_fsm_simd #(
    parameter int LANES   = 4,
    parameter int COORD_W = 16,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] img_width_out,
    input  logic [COORD_W-1:0] img_height_out,
    output logic               fetch_req,
    input  logic               fetch_done,
    output logic               dp_start,
    input  logic               dp_done,
    output logic               write_enable,
    input  logic               write_ready,
    output logic [LANES-1:0]   lane_valid,
    output logic [COORD_W-1:0] current_x,
    output logic [COORD_W-1:0] current_y,
    output logic [CNT_W-1:0]   pixels_processed,
    output logic               busy,
    output logic               ready,
`ifdef DSA_FSM_PERF_COUNTERS_EN
    output logic [31:0]        perf_cycles,
    output logic [31:0]        perf_stall,
`endif
    output logic               done_pulse
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_REQ_FETCH,
        ST_WAIT_FETCH,
        ST_START_DP,
        ST_WAIT_DP,
        ST_WRITE,
        ST_NEXT,
        ST_DONE
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [COORD_W:0]   x_nxt;
    logic               row_end;
    logic               last_grp;
    logic               active;
    logic [CNT_W-1:0]   pop;

    // Compare in COORD_W+1 bits so x+LANES never wraps near the top of the range.
    assign x_nxt    = {1'b0, current_x} + (COORD_W+1)'(LANES);
    assign row_end  = !(x_nxt < {1'b0, w});
    assign last_grp = row_end && (current_y == h - 1'b1);
    assign active   = (state == ST_REQ_FETCH) || (state == ST_WAIT_FETCH) ||
                      (state == ST_START_DP)  || (state == ST_WAIT_DP) ||
                      (state == ST_WRITE)     || (state == ST_NEXT);

    always_comb begin
        lane_valid = '0;
        pop        = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_valid[i] = active &&
                (({1'b0, current_x} + (COORD_W+1)'(i)) < {1'b0, w});
            pop = pop + CNT_W'(lane_valid[i]);
        end
    end

    always_comb begin
        state_n = state;
        if (abort && state != ST_IDLE) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: if (start) state_n = ST_INIT;
                ST_INIT:       state_n = (w == '0 || h == '0) ? ST_DONE : ST_REQ_FETCH;
                ST_REQ_FETCH:  state_n = ST_WAIT_FETCH;
                ST_WAIT_FETCH: if (fetch_done) state_n = ST_START_DP;
                ST_START_DP:   state_n = ST_WAIT_DP;
                ST_WAIT_DP:    if (dp_done) state_n = ST_WRITE;
                ST_WRITE:      if (write_ready) state_n = ST_NEXT;
                ST_NEXT:       state_n = last_grp ? ST_DONE : ST_REQ_FETCH;
                default:       state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            w                <= '0;
            h                <= '0;
            current_x        <= '0;
            current_y        <= '0;
            pixels_processed <= '0;
            fetch_req        <= 1'b0;
            dp_start         <= 1'b0;
            write_enable     <= 1'b0;
            busy             <= 1'b0;
            ready            <= 1'b0;
            done_pulse       <= 1'b0;
`ifdef DSA_FSM_PERF_COUNTERS_EN
            perf_cycles      <= '0;
            perf_stall       <= '0;
`endif
        end else begin
            state        <= state_n;
            fetch_req    <= (state_n == ST_REQ_FETCH);
            dp_start     <= (state_n == ST_START_DP);
            write_enable <= (state_n == ST_WRITE);
            busy         <= (state_n != ST_IDLE) && (state_n != ST_DONE);
            ready        <= (state_n == ST_DONE);
            done_pulse   <= (state_n == ST_DONE) && (state != ST_DONE);
            if (state_n == ST_INIT) begin
                w                <= img_width_out;
                h                <= img_height_out;
                current_x        <= '0;
                current_y        <= '0;
                pixels_processed <= '0;
            end else if (state == ST_NEXT && !abort) begin
                pixels_processed <= pixels_processed + pop;
                // The final group leaves the coordinates on itself.
                if (!last_grp) begin
                    if (row_end) begin
                        current_x <= '0;
                        current_y <= current_y + 1'b1;
                    end else begin
                        current_x <= x_nxt[COORD_W-1:0];
                    end
                end
            end
`ifdef DSA_FSM_PERF_COUNTERS_EN
            if (state_n == ST_INIT) begin
                perf_cycles <= '0;
                perf_stall  <= '0;
            end else begin
                if (state != ST_IDLE && state != ST_DONE)
                    perf_cycles <= perf_cycles + 1'b1;
                if ((state == ST_WAIT_FETCH && !fetch_done) ||
                    (state == ST_WAIT_DP && !dp_done) ||
                    (state == ST_WRITE && !write_ready))
                    perf_stall <= perf_stall + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dsa_control_fsm_simd.sv
// Scoreboard bench for dsa_control_fsm_simd (LANES=4): group order, masks, counts, abort, reset.
// Perf counter checks are compiled in when DSA_FSM_PERF_COUNTERS_EN is defined.
module tb_dsa_control_fsm_simd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] img_w;
    logic [15:0] img_h;
    logic        fetch_req;
    logic        fetch_done;
    logic        dp_start;
    logic        dp_done;
    logic        write_enable;
    logic        write_ready;
    logic [3:0]  lane_valid;
    logic [15:0] current_x;
    logic [15:0] current_y;
    logic [31:0] pixels_processed;
    logic        busy;
    logic        ready;
    logic        done_pulse;
`ifdef DSA_FSM_PERF_COUNTERS_EN
    logic [31:0] perf_cycles;
    logic [31:0] perf_stall;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    logic [35:0] sb[$];

    logic f_pend = 1'b0;
    logic d_pend = 1'b0;
    int   wr_cnt = 1;
    int   wr_next = 1;

    dsa_control_fsm_simd #(.LANES(4), .COORD_W(16), .CNT_W(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .img_width_out(img_w),
        .img_height_out(img_h),
        .fetch_req(fetch_req),
        .fetch_done(fetch_done),
        .dp_start(dp_start),
        .dp_done(dp_done),
        .write_enable(write_enable),
        .write_ready(write_ready),
        .lane_valid(lane_valid),
        .current_x(current_x),
        .current_y(current_y),
        .pixels_processed(pixels_processed),
        .busy(busy),
        .ready(ready),
`ifdef DSA_FSM_PERF_COUNTERS_EN
        .perf_cycles(perf_cycles),
        .perf_stall(perf_stall),
`endif
        .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    // Handshake partner: each done/ready arrives one cycle after its request.
    initial begin
        fetch_done  = 1'b0;
        dp_done     = 1'b0;
        write_ready = 1'b0;
        forever begin
            @(negedge clk);
            fetch_done = f_pend;
            f_pend     = fetch_req;
            dp_done    = d_pend;
            d_pend     = dp_start;
            if (write_enable) begin
                if (wr_cnt > 0) begin
                    wr_cnt--;
                    write_ready = 1'b0;
                end else begin
                    write_ready = 1'b1;
                    wr_next     = 1;
                end
            end else begin
                write_ready = 1'b0;
                wr_cnt      = wr_next;
            end
        end
    end

    task automatic push_frame(input int w, input int h);
        logic [3:0] lv;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x += 4) begin
                lv = '0;
                for (int i = 0; i < 4; i++)
                    if (x + i < w) lv[i] = 1'b1;
                sb.push_back({16'(x), 16'(y), lv});
            end
    endtask

    task automatic apply_start(input int w, input int h);
        @(negedge clk);
        img_w = 16'(w);
        img_h = 16'(h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs until ready, popping one scoreboard entry per fetch_req.
    task automatic frame_loop(input int budget, output int nfetch,
                              output int ndone, output int max_run);
        logic [35:0] e;
        int cyc = 0;
        int run = 0;
        bit got = 0;
        nfetch  = 0;
        ndone   = 0;
        max_run = 0;
        while (!got && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (fetch_req) begin
                nfetch++;
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL group: unexpected fetch at x=%0d y=%0d", current_x, current_y);
                end else begin
                    e = sb.pop_front();
                    if ({current_x, current_y, lane_valid} !== e) begin
                        n_fail++;
                        $display("FAIL group: got x=%0d y=%0d lv=%b, need x=%0d y=%0d lv=%b",
                                 current_x, current_y, lane_valid, e[35:20], e[19:4], e[3:0]);
                    end
                end
            end
            if (done_pulse) ndone++;
            run = write_enable ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (ready) got = 1;
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL frame_timeout: ready=%b after %0d cycles, need 1", ready, cyc);
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d groups left, need 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        n_chk++;
        if ({ready, done_pulse, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL done_hold: ready,pulse,busy=%b need 100", {ready, done_pulse, busy});
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        img_w = '0;
        img_h = '0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({fetch_req, dp_start, write_enable, busy, ready, done_pulse, lane_valid} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b need 0",
                     {fetch_req, dp_start, write_enable, busy, ready, done_pulse, lane_valid});
        end
        n_chk++;
        if ({current_x, current_y, pixels_processed} !== 64'b0) begin
            n_fail++;
            $display("FAIL reset_cnt: x=%0d y=%0d pix=%0d need 0",
                     current_x, current_y, pixels_processed);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_groups;
        int nf, nd, mr;
        push_frame(8, 2);
        apply_start(8, 2);
        img_w = 16'd3;
        img_h = 16'd9;
        frame_loop(400, nf, nd, mr);
        n_chk++;
        if (nf != 4 || nd != 1) begin
            n_fail++;
            $display("FAIL full_counts: fetch=%0d done=%0d need 4 1", nf, nd);
        end
        n_chk++;
        if (pixels_processed !== 32'd16) begin
            n_fail++;
            $display("FAIL full_pixels: got %0d need 16", pixels_processed);
        end
`ifdef DSA_FSM_PERF_COUNTERS_EN
        n_chk++;
        if (perf_cycles !== 32'd29 || perf_stall !== 32'd4) begin
            n_fail++;
            $display("FAIL full_perf: cycles=%0d stall=%0d need 29 4", perf_cycles, perf_stall);
        end
`endif
    endtask

    task automatic test_row_tail;
        int nf, nd, mr;
        push_frame(5, 1);
        apply_start(5, 1);
        frame_loop(400, nf, nd, mr);
        n_chk++;
        if (pixels_processed !== 32'd5 || nf != 2) begin
            n_fail++;
            $display("FAIL tail_pixels: pix=%0d fetch=%0d need 5 2", pixels_processed, nf);
        end
        n_chk++;
        if (current_y !== 16'd0) begin
            n_fail++;
            $display("FAIL tail_y: got %0d need 0", current_y);
        end
    endtask

    task automatic test_zero_dim;
        apply_start(0, 7);
        n_chk++;
        if ({busy, ready, fetch_req} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_init: busy,ready,fetch=%b need 100", {busy, ready, fetch_req});
        end
        @(negedge clk);
        n_chk++;
        if ({ready, done_pulse, fetch_req, busy} !== 4'b1100) begin
            n_fail++;
            $display("FAIL zero_done: ready,pulse,fetch,busy=%b need 1100",
                     {ready, done_pulse, fetch_req, busy});
        end
        n_chk++;
        if (pixels_processed !== 32'd0) begin
            n_fail++;
            $display("FAIL zero_pixels: got %0d need 0", pixels_processed);
        end
    endtask

    task automatic test_write_stall;
        int nf, nd, mr;
        push_frame(4, 4);
        wr_next = 10;
        apply_start(4, 4);
        frame_loop(600, nf, nd, mr);
        n_chk++;
        if (mr != 11) begin
            n_fail++;
            $display("FAIL stall_hold: longest write_enable run %0d need 11", mr);
        end
        n_chk++;
        if (pixels_processed !== 32'd16 || nf != 4) begin
            n_fail++;
            $display("FAIL stall_pixels: pix=%0d fetch=%0d need 16 4", pixels_processed, nf);
        end
`ifdef DSA_FSM_PERF_COUNTERS_EN
        n_chk++;
        if (perf_stall < 32'd10) begin
            n_fail++;
            $display("FAIL stall_perf: got %0d need >=10", perf_stall);
        end
`endif
    endtask

    task automatic test_abort;
        int ndp = 0;
        int cyc = 0;
        int nf, nd, mr;
        apply_start(8, 1);
        while (ndp < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (dp_start) ndp++;
        end
        n_chk++;
        if (ndp != 2) begin
            n_fail++;
            $display("FAIL abort_wait: dp_start pulses %0d need 2", ndp);
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_chk++;
        if ({busy, ready, fetch_req, dp_start, write_enable, lane_valid} !== 9'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got %b need 0",
                     {busy, ready, fetch_req, dp_start, write_enable, lane_valid});
        end
        n_chk++;
        if (current_x !== 16'd4 || pixels_processed !== 32'd4) begin
            n_fail++;
            $display("FAIL abort_keep: x=%0d pix=%0d need 4 4", current_x, pixels_processed);
        end
        repeat (3) @(negedge clk);
        push_frame(4, 1);
        apply_start(4, 1);
        frame_loop(200, nf, nd, mr);
        n_chk++;
        if (pixels_processed !== 32'd4 || nd != 1) begin
            n_fail++;
            $display("FAIL abort_restart: pix=%0d done=%0d need 4 1", pixels_processed, nd);
        end
    endtask

    task automatic test_mid_reset;
        int nf, nd, mr;
        apply_start(8, 2);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_chk++;
        if ({fetch_req, dp_start, write_enable, busy, ready, done_pulse, lane_valid,
             current_x, current_y, pixels_processed} !== 74'b0) begin
            n_fail++;
            $display("FAIL midreset_zero: x=%0d y=%0d pix=%0d ctl=%b need all 0",
                     current_x, current_y, pixels_processed,
                     {fetch_req, dp_start, write_enable, busy, ready, done_pulse, lane_valid});
        end
        push_frame(12, 3);
        apply_start(12, 3);
        frame_loop(600, nf, nd, mr);
        n_chk++;
        if (nf != 9 || pixels_processed !== 32'd36) begin
            n_fail++;
            $display("FAIL midreset_frame: fetch=%0d pix=%0d need 9 36", nf, pixels_processed);
        end
    endtask

    initial begin
        test_reset();
        test_full_groups();
        test_row_tail();
        test_zero_dim();
        test_write_stall();
        test_abort();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
